out_port_arb: RTL
=================

# out_port_arb

Output-port arbiter and packet switch for one router output direction. Takes the head flits of the five input queues, together with the direction vector each queue's address generator produced. It grants the output to one requesting queue at a time, using round-robin order, and holds that grant until the packet's tail flit has passed. Flits leave through a registered valid/ready output stage toward the neighbouring router or the local node. One instance sits on each of the five output ports.

## Interface
- PORT_DIR, 5'b00001: one-hot direction this instance serves. Bit order: [0] north, [1] south, [2] east, [3] west, [4] local.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_valid_i  input  5  bit i: input queue i has a flit at its head.
- in_flit_i  input  80  queue i head flit at [16i+15:16i]. Flit fields:
  - [15:14] type: 01 head, 00 body, 10 tail, 11 head+tail.
  - [7:0] destination address.
- in_dir_i  input  25  queue i requested direction at [5i+4:5i], one-hot; 00000 means invalid destination.
- out_ready_i  input  1  downstream accepts out_flit_o this cycle.
- pop_o  output  5  one-hot; dequeue the head of queue i this cycle. Combinational from state and inputs.
- out_valid_o  output  1  out_flit_o holds a valid flit. Registered.
- out_flit_o  output  16  flit toward downstream. Registered.

## Operation
- Request: req[i] = in_valid_i[i] & |(in_dir_i[i] & PORT_DIR) & (type is 01 or 11).
  - Body or tail flits at a queue head never raise a request.
  - in_dir_i = 00000 never matches any port; the flit stays at the queue head.
- States:
  - IDLE: no owner; pop_o = 0.
    - If any req: grant the first set bit found scanning ptr, ptr+1, … mod 5.
    - Latch owner = granted index. Set ptr = (owner+1) mod 5. Go to LOCK.
    - No pop in the grant cycle.
  - LOCK: let adv = in_valid_i[owner] & (!out_valid_o | out_ready_i).
    - pop_o[owner] = adv.
    - When adv: out_flit_o <= in_flit_i[owner]; out_valid_o <= 1.
    - If the popped flit type is 10 or 11, return to IDLE next edge.
    - Requests from other queues are ignored while in LOCK.
- Output stage when no new flit is loaded:
  - out_valid_o & out_ready_i: out_valid_o <= 0.
  - out_valid_o & !out_ready_i: out_flit_o and out_valid_o hold.
- ptr is a 3-bit value with range 0..4; mod-5 wrap goes from 4 to 0.

## Timing
- Reset values: state IDLE, ptr 0, owner 0, out_valid_o 0, out_flit_o 16'h0000, pop_o 5'b00000.
- Latency, head flit arriving at an IDLE arbiter with out_ready_i = 1:
  - Cycle 0: grant.
  - Cycle 1: pop_o asserted.
  - Edge 2: out_valid_o = 1.
- Throughput: one flit per cycle while in LOCK, when owner is valid and downstream ready.
- Bubble: the owner queue going empty mid-packet keeps LOCK with pop_o = 0. There is no timeout.
- Pop with stalled output is legal: out_valid_o = 1 and out_ready_i = 1 in the same cycle as adv. The register loads the new flit, so there is no gap.
- Tail popped in cycle n: IDLE at cycle n+1, next grant at cycle n+1, next pop at cycle n+2. One dead cycle between packets.
- Simultaneous requests in IDLE: only the round-robin winner is granted. The others keep requesting.
- Reset asserted mid-packet:
  - All state clears immediately and pop_o drops.
  - The remaining flits of the packet stay in the input queues. Upstream flushing them is outside this block.

## Test plan
- Reset mid-packet:
  - Stimulus: assert rst_i while in LOCK with out_valid_o = 1.
  - Response: out_valid_o = 0, pop_o = 0, out_flit_o = 0 without waiting for a clock edge. After release, the first grant scans from index 0.
- Single-flit packet:
  - Stimulus: PORT_DIR = 00001. Queue 2 head = 16'hC081 (type 11), dir 00001, out_ready_i = 1.
  - Response: pop_o = 00100 in cycle 1; out_flit_o = 16'hC081 with out_valid_o = 1 after edge 2; IDLE in cycle 2.
- Round-robin fairness:
  - Stimulus: queues 0, 3, 4 each hold a continuous supply of head+tail flits for this port.
  - Response: grant order 0, 3, 4, 0, 3, …, with ptr wrapping 4 → 0.
- Packet lock:
  - Stimulus: queue 1 sends head, body, body, tail. Queue 0 requests during this.
  - Response: all four flits from queue 1 go out consecutively. Queue 0 is granted only after the tail.
- Backpressure:
  - Stimulus: out_ready_i = 0 for 3 cycles during a packet.
  - Response: pop_o = 0 while the register is full; out_flit_o stable; no flit lost or duplicated.
- Non-matching or invalid direction:
  - Stimulus: queue 4 head with dir 00000, queue 2 head with dir 00100, PORT_DIR = 00001.
  - Response: no grant and pop_o = 0 indefinitely.

Source files
------------

// File: rtl/out_port_arb.sv
// Output-port arbiter: round-robin grant among five input queues, held for a whole packet,
// with a registered valid/ready output stage toward the downstream hop.
module out_port_arb #(
  parameter logic [4:0] PORT_DIR = 5'b00001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  in_valid_i,
  input  logic [79:0] in_flit_i,
  input  logic [24:0] in_dir_i,
  input  logic        out_ready_i,
  output logic [4:0]  pop_o,
  output logic        out_valid_o,
  output logic [15:0] out_flit_o
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ptr, ptr_nxt;
  logic [2:0]  owner, owner_nxt;
  logic [4:0]  req;
  logic [2:0]  grant;
  logic        grant_vld;
  logic [3:0]  scan_sum;
  logic [2:0]  scan_idx;
  logic [15:0] owner_flit;
  logic        owner_valid;
  logic        adv;

  // Only head-type flits (type bit 14 set: head or head+tail) aimed at this port request.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      req[i] = in_valid_i[i] & (|(in_dir_i[5*i +: 5] & PORT_DIR)) & in_flit_i[16*i + 14];
    end
  end

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      scan_sum = {1'b0, ptr} + 4'(k);
      scan_idx = (scan_sum >= 4'd5) ? 3'(scan_sum - 4'd5) : scan_sum[2:0];
      if (!grant_vld && req[scan_idx]) begin
        grant     = scan_idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    owner_flit  = '0;
    owner_valid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (owner == 3'(i)) begin
        owner_flit  = in_flit_i[16*i +: 16];
        owner_valid = in_valid_i[i];
      end
    end
  end

  assign adv = (state == LOCK) & owner_valid & (~out_valid_o | out_ready_i);

  always_comb begin
    pop_o = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      pop_o[i] = adv & (owner == 3'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = LOCK;
          owner_nxt = grant;
          ptr_nxt   = (grant == 3'd4) ? '0 : grant + 3'd1;
        end
      end
      LOCK: begin
        // Tail and head+tail both have bit 15 set.
        if (adv && owner_flit[15]) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_flit_o  <= '0;
    end else if (adv) begin
      out_valid_o <= 1'b1;
      out_flit_o  <= owner_flit;
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
